uart_word_tx: RTL and testbench

Word-level UART transmitter, the sending half of the design's serial link. It accepts one DATA_BITS-wide word per valid/ready handshake and serializes it onto tx_o as DATA_BITS/8 consecutive 8N1 frames, least-significant byte first and LSB-first within each byte. It sits between the signal-processing core and the board TX pin, alongside the existing UART receive path, and uses the same DATA_BITS, BAUD_RATE and CLK_FREQ settings.

---
 rtl/uart_word_tx.sv | 144 ++++++++++++++
 tb/tb_uart_word_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// Word-level UART transmitter: one DATA_BITS word per handshake, sent as
// BYTES back-to-back 8N1 frames, LSB byte first. UART_TX_PARITY_EN adds even parity.
module uart_word_tx #(
   parameter int DATA_BITS = 24,
   parameter int BAUD_RATE = 9600,
   parameter int CLK_FREQ  = 50000000
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [DATA_BITS-1:0] data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic                 busy_o,
   output logic                 tx_o
);

   localparam int BYTES        = DATA_BITS / 8;
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(BYTES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BYTES - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t               state, state_n;
   logic [TW-1:0]        timer, timer_n;
   logic [2:0]           bit_idx, bit_n;
   logic [BW-1:0]        byte_cnt, byte_n;
   logic [DATA_BITS-1:0] shreg, sh_n;
   logic                 tx_n, ready_n, busy_n;
   logic                 wrap, last_stop, accept;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state    <= IDLE;
         timer    <= '0;
         bit_idx  <= '0;
         byte_cnt <= '0;
         shreg    <= '0;
         tx_o     <= 1'b1;
         ready_o  <= 1'b0;
         busy_o   <= 1'b0;
      end else begin
         state    <= state_n;
         timer    <= timer_n;
         bit_idx  <= bit_n;
         byte_cnt <= byte_n;
         shreg    <= sh_n;
         tx_o     <= tx_n;
         ready_o  <= ready_n;
         busy_o   <= busy_n;
      end
   end

   // The final stop-bit wrap also accepts, so held valid gives no idle gap
   assign wrap      = (timer == T_LAST);
   assign last_stop = (state == STOP) && wrap && (byte_cnt == B_LAST);
   assign accept    = valid_i && (ready_o || last_stop);

   always_comb begin
      state_n = state;
      timer_n = '0;
      bit_n   = bit_idx;
      byte_n  = byte_cnt;
      sh_n    = shreg;
      if (state != IDLE)
         timer_n = wrap ? '0 : timer + 1'b1;
      unique case (state)
         IDLE: ;
         START: begin
            if (wrap) begin
               state_n = DATA;
               bit_n   = 3'd0;
            end
         end
         DATA: begin
            if (wrap) begin
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
                  bit_n = 3'd0;
               end else begin
                  bit_n = bit_idx + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (wrap)
               state_n = STOP;
         end
`endif
         STOP: begin
            if (wrap) begin
               if (byte_cnt == B_LAST) begin
                  state_n = IDLE;
               end else begin
                  state_n = START;
                  byte_n  = byte_cnt + 1'b1;
                  sh_n    = shreg >> 8;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (accept) begin
         state_n = START;
         timer_n = '0;
         bit_n   = 3'd0;
         byte_n  = '0;
         sh_n    = data_i;
      end
   end

   // Line level is derived from the next state so tx_o is purely registered
   always_comb begin
      tx_n = 1'b1;
      unique case (state_n)
         IDLE:  tx_n = 1'b1;
         START: tx_n = 1'b0;
         DATA:  tx_n = sh_n[bit_n];
`ifdef UART_TX_PARITY_EN
         PARITY: tx_n = ^sh_n[7:0];
`endif
         STOP:  tx_n = 1'b1;
         default: tx_n = 1'b1;
      endcase
      ready_n = (state_n == IDLE);
      busy_n  = !ready_n;
   end

endmodule

// File: tb/tb_uart_word_tx.sv
// Scoreboard bench for uart_word_tx: stimulus queues expected bytes,
// a line-decoder process pops and checks each received frame.
module tb_uart_word_tx;

   localparam int C = 10;
`ifdef UART_TX_PARITY_EN
   localparam int F = 11;
`else
   localparam int F = 10;
`endif
   localparam int W = 3 * F * C;

   logic        clk = 1'b0;
   logic        rstn;
   logic [23:0] data;
   logic        valid;
   logic        ready, busy, tx;

   logic [7:0]  exp_q[$];
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   uart_word_tx #(
      .DATA_BITS(24),
      .BAUD_RATE(100000),
      .CLK_FREQ(1000000)
   ) dut (
      .clk_i(clk),
      .rstn_i(rstn),
      .data_i(data),
      .valid_i(valid),
      .ready_o(ready),
      .busy_o(busy),
      .tx_o(tx)
   );

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Line decoder: sample each bit mid-period, compare the whole frame
   initial begin
      logic [10:0] fr;
      logic [10:0] ef;
      logic [7:0]  b;
      int          cnt;
      bit          run;
      run = 0;
      cnt = 0;
      fr  = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            run = 0;
         end else if (!run) begin
            if (tx === 1'b0) begin
               run = 1;
               cnt = 0;
               fr  = '0;
            end
         end else begin
            cnt++;
         end
         if (run && (cnt % C) == C / 2) begin
            fr[cnt / C] = tx;
            if (cnt / C == F - 1) begin
               run = 0;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_frame got=%0h exp=none", fr);
               end else begin
                  b = exp_q.pop_front();
                  ef = '0;
                  ef[8:1] = b;
`ifdef UART_TX_PARITY_EN
                  ef[9] = ^b;
`endif
                  ef[F-1] = 1'b1;
                  chk("frame", 32'(fr), 32'(ef));
               end
            end
         end
      end
   end

   // Drive at a negedge; the next posedge is the accept edge N.
   // Returns at N+0.5 with valid dropped.
   task automatic start_word(input logic [23:0] d, input int nb);
      data  = d;
      valid = 1'b1;
      for (int i = 0; i < nb; i++)
         exp_q.push_back(d[8*i +: 8]);
      @(negedge clk);
      valid = 1'b0;
      chk("accept_ready", 32'(ready), 0);
      chk("accept_busy", 32'(busy), 1);
      chk("accept_start", 32'(tx), 0);
   endtask

   // From N+el+0.5 run to N+W+0.5, checking the ready edge and stop bit
   task automatic finish_word(input int el);
      repeat (W - 1 - el) @(negedge clk);
      chk("last_ready", 32'(ready), 0);
      chk("last_stop", 32'(tx), 1);
      @(negedge clk);
      chk("done_ready", 32'(ready), 1);
      chk("done_busy", 32'(busy), 0);
      chk("done_line", 32'(tx), 1);
   endtask

   initial begin
      rstn  = 1'b0;
      valid = 1'b1;
      data  = 24'hFFFFFF;
      repeat (5) begin
         @(negedge clk);
         chk("rst_tx", 32'(tx), 1);
         chk("rst_ready", 32'(ready), 0);
      end
      rstn = 1'b1;
      @(negedge clk);
      chk("rel_ready", 32'(ready), 1);
      chk("rel_busy", 32'(busy), 0);
      chk("rel_no_xfer", 32'(tx), 1);
      valid = 1'b0;
      repeat (3) @(negedge clk);

      start_word(24'hA5C33C, 3);
      finish_word(0);
      repeat (3) @(negedge clk);

      start_word(24'h000001, 3);
      data  = 24'hFFFFFF;
      valid = 1'b1;
      for (int i = 0; i < 3; i++)
         exp_q.push_back(8'hFF);
      repeat (W - 1) @(negedge clk);
      chk("b2b_last_ready", 32'(ready), 0);
      chk("b2b_last_stop", 32'(tx), 1);
      @(negedge clk);
      valid = 1'b0;
      chk("b2b_ready", 32'(ready), 0);
      chk("b2b_busy", 32'(busy), 1);
      chk("b2b_start", 32'(tx), 0);
      finish_word(0);
      repeat (3) @(negedge clk);

      start_word(24'h000000, 3);
      repeat (49) @(negedge clk);
      data  = 24'h123456;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      chk("ign_busy", 32'(busy), 1);
      finish_word(50);
      repeat (3) @(negedge clk);

      start_word(24'hAABBCC, 1);
      repeat (124) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      chk("mid_rst_tx", 32'(tx), 1);
      chk("mid_rst_ready", 32'(ready), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("mid_rel_ready", 32'(ready), 1);
      chk("mid_rel_tx", 32'(tx), 1);
      start_word(24'h0F0F0F, 3);
      finish_word(0);
      repeat (3) @(negedge clk);

`ifdef UART_TX_PARITY_EN
      start_word(24'h010300, 3);
      finish_word(0);
      repeat (3) @(negedge clk);
`endif

      repeat (20) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
